// File: rtl/sys_regfile_ctrl.sv
// sys_regfile_ctrl
//   Command-side initiator for the system register file. Parses a byte stream
//   from the UART receive path into write frames (WR_CMD, addr, data) and read
//   frames (RD_CMD, addr). A write frame issues one write-enable pulse. A read
//   frame issues one read-enable pulse, captures the returned data and offers
//   it to the UART transmit path over a valid/ready handshake.
//
//   Optional feature: define REGFILE_CTRL_TIMEOUT_EN to abort partial frames
//   that stall in WR_ADDR, WR_DATA or RD_ADDR for TIMEOUT_CYCLES-1 cycles.
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_rx_data   received byte
//   i_rx_valid  one-cycle strobe, i_rx_data valid
//   o_rf_addr   register-file address
//   o_rf_wdata  register-file write data
//   o_rf_en_w   register-file write enable (one-cycle pulse)
//   o_rf_en_r   register-file read enable (one-cycle pulse)
//   i_rf_rdata  register-file read data, valid the cycle after o_rf_en_r
//   o_tx_data   byte to transmit
//   o_tx_valid  o_tx_data valid, held until accepted
//   i_tx_ready  transmitter accepts when high with o_tx_valid
//   o_busy      high in every state except IDLE
//   o_err       one-cycle pulse on protocol error
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for a command byte
// WR_ADDR  | write frame, waiting for the address byte
// WR_DATA  | write frame, waiting for the data byte
// WR_ISSUE | o_rf_en_w driven this cycle
// RD_ADDR  | read frame, waiting for the address byte
// RD_ISSUE | o_rf_en_r driven this cycle
// RD_WAIT  | register file presents read data this cycle
// TX_SEND  | o_tx_valid held until i_tx_ready
module sys_regfile_ctrl #(
    parameter int              WIDTH          = 8,
    parameter int              ADDR_W         = 4,
    parameter logic [WIDTH-1:0] WR_CMD        = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD        = 8'hBB,
    parameter int              TIMEOUT_CYCLES = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [WIDTH-1:0]  i_rx_data,
    input  logic              i_rx_valid,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic [WIDTH-1:0]  o_rf_wdata,
    output logic              o_rf_en_w,
    output logic              o_rf_en_r,
    input  logic [WIDTH-1:0]  i_rf_rdata,
    output logic [WIDTH-1:0]  o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_err
);

    if (TIMEOUT_CYCLES < 2 || WIDTH <= ADDR_W) begin : g_bad_params
        $error("sys_regfile_ctrl: need TIMEOUT_CYCLES >= 2 and WIDTH > ADDR_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_ISSUE,
        S_RD_ADDR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_TX_SEND
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [WIDTH-1:0]  wdata_n;
    logic [WIDTH-1:0]  tx_data_n;
    logic              en_w_n, en_r_n, tx_valid_n, busy_n, err_n;
    logic              addr_ok;

    // An address byte is legal only if the bits above the file's address
    // range are all zero.
    assign addr_ok = (i_rx_data[WIDTH-1:ADDR_W] == '0);

`ifdef REGFILE_CTRL_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    // Down-counter: reloaded on every accepted byte and outside timed states;
    // terminal count 0 equals TIMEOUT_CYCLES-1 cycles without a byte.
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic             timed_state;

    assign timed_state = (state == S_WR_ADDR) || (state == S_WR_DATA) ||
                         (state == S_RD_ADDR);
`endif

    always_comb begin
        state_n    = state;
        addr_n     = o_rf_addr;
        wdata_n    = o_rf_wdata;
        tx_data_n  = o_tx_data;
        tx_valid_n = o_tx_valid;
        en_w_n     = 1'b0;
        en_r_n     = 1'b0;
        err_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == WR_CMD)      state_n = S_WR_ADDR;
                    else if (i_rx_data == RD_CMD) state_n = S_RD_ADDR;
                    else                          err_n   = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (i_rx_valid) begin
                    if (addr_ok) begin
                        addr_n  = i_rx_data[ADDR_W-1:0];
                        state_n = S_WR_DATA;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_WR_DATA: begin
                if (i_rx_valid) begin
                    wdata_n = i_rx_data;
                    en_w_n  = 1'b1;
                    state_n = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                err_n   = i_rx_valid;
                state_n = S_IDLE;
            end
            S_RD_ADDR: begin
                if (i_rx_valid) begin
                    if (addr_ok) begin
                        addr_n  = i_rx_data[ADDR_W-1:0];
                        en_r_n  = 1'b1;
                        state_n = S_RD_ISSUE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_RD_ISSUE: begin
                err_n   = i_rx_valid;
                state_n = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // The file registers its output, so the data is on
                // i_rf_rdata during this cycle.
                err_n      = i_rx_valid;
                tx_data_n  = i_rf_rdata;
                tx_valid_n = 1'b1;
                state_n    = S_TX_SEND;
            end
            S_TX_SEND: begin
                err_n = i_rx_valid;
                if (i_tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            default: begin
                state_n    = S_IDLE;
                tx_valid_n = 1'b0;
            end
        endcase

`ifdef REGFILE_CTRL_TIMEOUT_EN
        tmo_cnt_n = TMO_LOAD;
        if (timed_state && !i_rx_valid) begin
            if (tmo_cnt == '0) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end else begin
                tmo_cnt_n = tmo_cnt - 1'b1;
            end
        end
`endif

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            o_rf_addr  <= '0;
            o_rf_wdata <= '0;
            o_rf_en_w  <= 1'b0;
            o_rf_en_r  <= 1'b0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_n;
            o_rf_addr  <= addr_n;
            o_rf_wdata <= wdata_n;
            o_rf_en_w  <= en_w_n;
            o_rf_en_r  <= en_r_n;
            o_tx_data  <= tx_data_n;
            o_tx_valid <= tx_valid_n;
            o_busy     <= busy_n;
            o_err      <= err_n;
        end
    end

`ifdef REGFILE_CTRL_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) tmo_cnt <= TMO_LOAD;
        else       tmo_cnt <= tmo_cnt_n;
    end
`endif

endmodule
